// File: rtl/sigmoid_rr_sched.sv
// rtl/sigmoid_rr_sched.sv - round-robin scheduler feeding one shared Q16.16 sigmoid datapath
module sigmoid_rr_sched #(
  parameter int NREQ    = 4,
  parameter int MUL_LAT = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*32-1:0]       req_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_data,
  output logic [$clog2(NREQ)-1:0]  out_id,
  output logic                     out_sat,
  output logic                     busy
);
  localparam int ID_W  = $clog2(NREQ);
  localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic signed [31:0] NEG_LIM = -32'sd65536;
  localparam logic signed [31:0] POS_LIM = 32'sd65535;
  localparam logic signed [63:0] ONE_Q28 = 64'sd268435456;

  typedef enum logic [2:0] {IDLE, S1, MUL, S2, OUT} state_t;

  state_t                state, state_n;
  logic [ID_W-1:0]       ptr, grant_id, scan_idx, id_q;
  logic                  grant_any;
  logic [CNT_W-1:0]      mul_cnt;
  logic                  mul_last;
  logic signed [31:0]    x_q, s_q, abs_x, a_val, s_n;
  logic                  sat_q, sat_n;
  logic signed [63:0]    s_ext, prod, p_q, t_v, res_n;

  // Search starts just past the last winner so every requester gets a turn.
  always_comb begin
    req_ready = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    scan_idx  = '0;
    if (state == IDLE) begin
      for (int k = 1; k <= NREQ; k++) begin
        scan_idx = ID_W'((int'(ptr) + k) % NREQ);
        if (!grant_any && req_valid[scan_idx]) begin
          grant_any = 1'b1;
          grant_id  = scan_idx;
        end
      end
      if (grant_any) req_ready[grant_id] = 1'b1;
    end
  end

  assign mul_last = (mul_cnt == CNT_W'(MUL_LAT - 1));
  assign busy     = (state != IDLE);

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (grant_any) state_n = S1;
      S1:      state_n = MUL;
      MUL:     if (mul_last) state_n = S2;
      S2:      state_n = OUT;
      OUT:     if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Most negative input has no positive twin; clamp its magnitude instead.
  always_comb begin
    abs_x = x_q;
    if (x_q[31]) abs_x = (x_q == 32'sh80000000) ? 32'sh7FFFFFFF : -x_q;
    a_val = abs_x >>> 2;
    s_n   = '0;
    sat_n = 1'b0;
    if (x_q[31]) begin
      if (x_q > NEG_LIM) s_n = a_val - 32'sd16384;
      else begin
        s_n   = 32'sd0;
        sat_n = 1'b1;
      end
    end else begin
      if (x_q < POS_LIM) s_n = 32'sd16384 - a_val;
      else begin
        s_n   = 32'sd1;
        sat_n = 1'b1;
      end
    end
  end

  always_comb begin
    s_ext = {{32{s_q[31]}}, s_q};
    prod  = s_ext * s_ext;
    t_v   = p_q >>> 1;
    res_n = x_q[31] ? t_v : (ONE_Q28 - t_v);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= ID_W'(NREQ - 1);
      x_q       <= '0;
      id_q      <= '0;
      s_q       <= '0;
      sat_q     <= 1'b0;
      p_q       <= '0;
      mul_cnt   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
      out_sat   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (grant_any) begin
          x_q  <= req_data[32*grant_id +: 32];
          id_q <= grant_id;
          ptr  <= grant_id;
        end
        S1: begin
          s_q     <= s_n;
          sat_q   <= sat_n;
          mul_cnt <= '0;
        end
        MUL: begin
          if (mul_last) begin
            p_q     <= prod;
            mul_cnt <= '0;
          end else begin
            mul_cnt <= mul_cnt + CNT_W'(1);
          end
        end
        S2: begin
          out_data  <= res_n[31:0];
          out_id    <= id_q;
          out_sat   <= sat_q;
          out_valid <= 1'b1;
        end
        OUT: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sigmoid_rr_sched.sv
// tb/tb_sigmoid_rr_sched.sv - vector table and scoreboard bench for sigmoid_rr_sched
module tb_sigmoid_rr_sched;
  localparam int NREQ    = 4;
  localparam int MUL_LAT = 2;

  logic                clk;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*32-1:0]  req_data;
  logic                out_valid;
  logic                out_ready;
  logic [31:0]         out_data;
  logic [1:0]          out_id;
  logic                out_sat;
  logic                busy;

  sigmoid_rr_sched #(.NREQ(NREQ), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_id(out_id), .out_sat(out_sat), .busy(busy)
  );

  typedef struct { int r; logic [31:0] x; logic [31:0] d; logic sat; } vec_t;
  typedef struct { logic [31:0] d; int id; logic sat; int acc; } exp_t;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t q[$];
  logic prev_v = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (out_valid && !prev_v) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_out: got data %0h want no result", out_data);
      end else begin
        e = q.pop_front();
        check("out_data", out_data, e.d);
        check("out_id", out_id, e.id);
        check("out_sat", out_sat, e.sat);
        check("latency", cyc - e.acc, MUL_LAT + 2);
      end
    end
    prev_v = out_valid;
  end

  task automatic do_req(input int r, input logic [31:0] x, input logic [31:0] ed, input logic es);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    req_valid = '0;
    req_valid[r] = 1'b1;
    req_data[32*r +: 32] = x;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (req_ready != 0) got = 1'b1;
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL grant_timeout: got none want requester %0d", r);
    end else begin
      check("grant", req_ready, 1 << r);
      q.push_back('{d: ed, id: r, sat: es, acc: cyc + 1});
    end
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    check("busy_after_accept", busy, 1);
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 80 && !done; n++) begin
      @(negedge clk);
      if (!busy && !out_valid && q.size() == 0) done = 1'b1;
    end
    check("drain", done, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    vec_t vt[14];
    logic [31:0] rr_d[4];
    logic        rr_s[4];
    int nacc;
    int last;

    vt[0]  = '{0, 32'h00000000, 32'h08000000, 1'b0};
    vt[1]  = '{2, 32'hFFFFFFFC, 32'h07FFC000, 1'b0};
    vt[2]  = '{2, 32'h00000004, 32'h08004000, 1'b0};
    vt[3]  = '{1, 32'h00010000, 32'h10000000, 1'b1};
    vt[4]  = '{3, 32'hFFFF0000, 32'h00000000, 1'b1};
    vt[5]  = '{0, 32'h0000FFFF, 32'h10000000, 1'b1};
    vt[6]  = '{1, 32'h0000FFFE, 32'h10000000, 1'b0};
    vt[7]  = '{3, 32'hFFFF0001, 32'h00000000, 1'b0};
    vt[8]  = '{2, 32'h00008000, 32'h0E000000, 1'b0};
    vt[9]  = '{1, 32'hFFFF8000, 32'h02000000, 1'b0};
    vt[10] = '{0, 32'h80000000, 32'h00000000, 1'b1};
    vt[11] = '{3, 32'h7FFFFFFF, 32'h10000000, 1'b1};
    vt[12] = '{2, 32'h0000A000, 32'h0EE00000, 1'b0};
    vt[13] = '{1, 32'hFFFFC000, 32'h04800000, 1'b0};

    rr_d[0] = 32'h08000000; rr_s[0] = 1'b0;
    rr_d[1] = 32'h07FFC000; rr_s[1] = 1'b0;
    rr_d[2] = 32'h08004000; rr_s[2] = 1'b0;
    rr_d[3] = 32'h10000000; rr_s[3] = 1'b1;

    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_id", out_id, 0);
    check("rst_out_sat", out_sat, 0);
    check("rst_busy", busy, 0);
    check("rst_req_ready", req_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      do_req(vt[i].r, vt[i].x, vt[i].d, vt[i].sat);
      wait_idle();
    end

    // Output back-pressure: results must hold and no new grant may issue.
    out_ready = 1'b0;
    do_req(0, 32'h00000004, 32'h08004000, 1'b0);
    @(posedge clk); #1;
    req_valid = 4'b1000;
    req_data[127:96] = 32'hFFFFFFFC;
    begin
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < 20 && !seen; n++) begin
        @(negedge clk);
        if (out_valid) seen = 1'b1;
      end
      check("stall_out_valid_rise", seen, 1);
    end
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      check("stall_valid", out_valid, 1);
      check("stall_data", out_data, 32'h08004000);
      check("stall_id", out_id, 0);
      check("stall_sat", out_sat, 0);
      check("stall_req_ready", req_ready, 0);
      check("stall_busy", busy, 1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("release_out_valid", out_valid, 0);
    check("release_grant", req_ready, 4'b1000);
    q.push_back('{d: 32'h07FFC000, id: 3, sat: 1'b0, acc: cyc + 1});
    @(posedge clk); #1;
    req_valid = '0;
    wait_idle();

    // Reset while in the multiply stage discards the operation.
    @(posedge clk); #1;
    req_valid = 4'b0100;
    req_data[95:64] = 32'h00008000;
    begin
      bit got;
      got = 1'b0;
      for (int n = 0; n < 20 && !got; n++) begin
        @(negedge clk);
        if (req_ready != 0) got = 1'b1;
      end
      check("midrst_grant", req_ready, 4'b0100);
    end
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    check("midrst_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_out_id", out_id, 0);
    check("midrst_out_sat", out_sat, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("midrst_no_result", out_valid, 0);

    // All requesters valid: fair rotation starting from requester 0.
    @(posedge clk); #1;
    req_valid = 4'hF;
    req_data  = {32'h00010000, 32'h00000004, 32'hFFFFFFFC, 32'h00000000};
    nacc = 0;
    last = 0;
    for (int n = 0; n < 120 && nacc < 8; n++) begin
      @(negedge clk);
      if (req_ready != 0) begin
        check("rr_grant", req_ready, 1 << (nacc % 4));
        if (nacc > 0) check("rr_spacing", cyc - last, MUL_LAT + 4);
        last = cyc;
        q.push_back('{d: rr_d[nacc % 4], id: nacc % 4, sat: rr_s[nacc % 4], acc: cyc + 1});
        nacc++;
      end
    end
    check("rr_accepts", nacc, 8);
    @(posedge clk); #1;
    req_valid = '0;
    wait_idle();
    check("queue_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
